// File: rtl/divui_share_ctrl_pkg.sv
// Shared types and helpers for the shared-divider controller.
// Tags are stored at a fixed maximum width so the tracker entry can live here.
package divui_share_ctrl_pkg;

  localparam int TAG_MAX_W = 8;

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
  } trk_entry_t;

  // Tag width for N requesters; never below one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divui_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping mod N, and moves the pointer past the winner on each enabled grant.
module rr_arbiter
  import divui_share_ctrl_pkg::*;
#(
  parameter  int N     = 2,
  localparam int TAG_W = tag_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [TAG_W-1:0] grant_idx,
  output logic             any,
  output logic [TAG_W-1:0] ptr
);

  // Outer loop walks priority distance from ptr, inner loop finds that requester.
  always_comb begin : arb
    int d;
    grant     = '0;
    grant_idx = ptr;
    any       = 1'b0;
    d         = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        d = i - int'(ptr);
        if (d < 0) d = d + N;
        if (!any && req[i] && d == k) begin
          any       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = TAG_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && any)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/divui_share_ctrl.sv
// Shares one pipelined divider among N elastic requesters: round-robin issue,
// tag tracker aligned with the divider pipe, in-order result steering.
module divui_share_ctrl
  import divui_share_ctrl_pkg::*;
#(
  parameter int N        = 2,
  parameter int BITWIDTH = 32,
  parameter int LATENCY  = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*BITWIDTH-1:0] lhs,
  input  logic [N-1:0]          lhs_valid,
  output logic [N-1:0]          lhs_ready,
  input  logic [N*BITWIDTH-1:0] rhs,
  input  logic [N-1:0]          rhs_valid,
  output logic [N-1:0]          rhs_ready,
  output logic [N*BITWIDTH-1:0] result,
  output logic [N-1:0]          result_valid,
  input  logic [N-1:0]          result_ready,
  output logic                  div_ce,
  output logic [BITWIDTH-1:0]   div_din0,
  output logic [BITWIDTH-1:0]   div_din1,
  input  logic [BITWIDTH-1:0]   div_dout
);

  localparam int TAG_W = tag_w(N);

  trk_entry_t       trk [LATENCY];
  logic [N-1:0]     req, grant, head_sel;
  logic [TAG_W-1:0] grant_idx, ptr, op_sel;
  logic             any, issue;

  assign req = lhs_valid & rhs_valid;

  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (div_ce),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any),
    .ptr       (ptr)
  );

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < N; i++)
      head_sel[i] = trk[LATENCY-1].vld && (trk[LATENCY-1].tag == TAG_MAX_W'(i));
  end

  // Only the head's consumer can stall the pipe; request valids never reach ce.
  assign div_ce = ~trk[LATENCY-1].vld | (|(head_sel & result_ready));
  assign issue  = div_ce & any;

  assign lhs_ready = issue ? grant : '0;
  assign rhs_ready = issue ? grant : '0;

  assign op_sel   = any ? grant_idx : ptr;
  assign div_din0 = lhs[int'(op_sel)*BITWIDTH +: BITWIDTH];
  assign div_din1 = rhs[int'(op_sel)*BITWIDTH +: BITWIDTH];

  assign result_valid = head_sel;
  assign result       = {N{div_dout}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) trk[k] <= '0;
    end else if (div_ce) begin
      trk[0].vld <= issue;
      trk[0].tag <= TAG_MAX_W'(grant_idx);
      for (int k = 1; k < LATENCY; k++) trk[k] <= trk[k-1];
    end
  end

endmodule

// File: tb/tb_divui_share_ctrl.sv
// Directed bench for divui_share_ctrl with N=2, LATENCY=4 and a behavioural divider.
module tb_divui_share_ctrl;
  localparam int N = 2, BW = 32, LAT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*BW-1:0] lhs, rhs, result;
  logic [N-1:0]    lhs_valid, rhs_valid, lhs_ready, rhs_ready;
  logic [N-1:0]    result_valid, result_ready;
  logic            div_ce;
  logic [BW-1:0]   div_din0, div_din1, div_dout;
  logic [BW-1:0]   dq [LAT];
  int              n_cmp = 0, n_err = 0;

  divui_share_ctrl #(.N(N), .BITWIDTH(BW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .div_ce(div_ce),
    .div_din0(div_din0), .div_din1(div_din1), .div_dout(div_dout)
  );

  always #5 clk = ~clk;

  // Behavioural divider core: LAT ce-enabled stages.
  always @(posedge clk) begin
    if (div_ce) begin
      dq[0] <= (div_din1 == 0) ? '1 : div_din0 / div_din1;
      for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
    end
  end
  assign div_dout = dq[LAT-1];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    lhs_valid = '0; rhs_valid = '0;
  endtask

  task automatic test_reset();
    idle(); result_ready = '1; lhs = '0; rhs = '0;
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL reset_rv got %b want 00", result_valid); end
    n_cmp++; if (div_ce !== 1'b1) begin n_err++; $display("FAIL reset_ce got %b want 1", div_ce); end
    n_cmp++; if (lhs_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", lhs_ready); end
  endtask

  task automatic test_single();
    lhs[31:0] = 100; rhs[31:0] = 7; lhs_valid = 2'b01; rhs_valid = 2'b01; #1;
    n_cmp++; if (lhs_ready !== 2'b01 || rhs_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b/%b want 01/01", lhs_ready, rhs_ready); end
    n_cmp++; if (div_din0 !== 100 || div_din1 !== 7) begin n_err++; $display("FAIL single_din got %0d/%0d want 100/7", div_din0, div_din1); end
    tick(); idle(); tick(); tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL single_early got %b want 00", result_valid); end
    tick();
    n_cmp++; if (result_valid !== 2'b01) begin n_err++; $display("FAIL single_rv got %b want 01", result_valid); end
    n_cmp++; if (result[31:0] !== 14 || result[63:32] !== 14) begin n_err++; $display("FAIL single_res got %0d/%0d want 14/14", result[31:0], result[63:32]); end
    tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL single_after got %b want 00", result_valid); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g [4];
    logic [31:0]  exp_r [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_r = '{32'd42, 32'd30, 32'd42, 32'd30};
    rst = 1'b1; tick(); rst = 1'b0;
    lhs = {32'd90, 32'd84}; rhs = {32'd3, 32'd2};
    for (int c = 0; c < 4; c++) begin
      lhs_valid = 2'b11; rhs_valid = 2'b11; #1;
      n_cmp++; if (lhs_ready !== exp_g[c]) begin n_err++; $display("FAIL fair_grant%0d got %b want %b", c, lhs_ready, exp_g[c]); end
      tick();
    end
    idle(); #1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (result_valid !== exp_g[c] || result[31:0] !== exp_r[c]) begin
        n_err++; $display("FAIL fair_res%0d got %b:%0d want %b:%0d", c, result_valid, result[31:0], exp_g[c], exp_r[c]);
      end
      tick();
    end
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL fair_after got %b want 00", result_valid); end
  endtask

  task automatic test_backpressure();
    // ptr is 0 here; only requester 1 asks.
    result_ready = 2'b01;
    lhs[63:32] = 50; rhs[63:32] = 5; lhs_valid = 2'b10; rhs_valid = 2'b10; #1;
    n_cmp++; if (lhs_ready !== 2'b10) begin n_err++; $display("FAIL bp_issue got %b want 10", lhs_ready); end
    tick(); idle(); tick(); tick(); tick();
    lhs[31:0] = 81; rhs[31:0] = 9; lhs_valid = 2'b01; rhs_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (div_ce !== 1'b0 || lhs_ready !== 2'b00 || rhs_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_stall%0d got ce=%b rdy=%b/%b want 0 00/00", c, div_ce, lhs_ready, rhs_ready);
      end
      n_cmp++; if (result_valid !== 2'b10 || result[63:32] !== 10) begin
        n_err++; $display("FAIL bp_hold%0d got %b:%0d want 10:10", c, result_valid, result[63:32]);
      end
      if (c < 3) tick();
    end
    result_ready = 2'b11; #1;
    n_cmp++; if (div_ce !== 1'b1 || lhs_ready !== 2'b01) begin n_err++; $display("FAIL bp_resume got ce=%b rdy=%b want 1 01", div_ce, lhs_ready); end
    tick(); idle(); #1;
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL bp_nodup got %b want 00", result_valid); end
    tick(); tick(); tick();
    n_cmp++; if (result_valid !== 2'b01 || result[31:0] !== 9) begin n_err++; $display("FAIL bp_next got %b:%0d want 01:9", result_valid, result[31:0]); end
    tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL bp_after got %b want 00", result_valid); end
  endtask

  task automatic test_bubbles();
    lhs[31:0] = 25; rhs[31:0] = 5; lhs_valid = 2'b01; rhs_valid = 2'b01; #1;
    n_cmp++; if (lhs_ready !== 2'b01) begin n_err++; $display("FAIL bub_issue0 got %b want 01", lhs_ready); end
    tick(); idle(); tick();
    lhs[31:0] = 9; rhs[31:0] = 3; lhs_valid = 2'b01; rhs_valid = 2'b01;
    tick(); idle(); tick();
    n_cmp++; if (result_valid !== 2'b01 || result[31:0] !== 5) begin n_err++; $display("FAIL bub_r0 got %b:%0d want 01:5", result_valid, result[31:0]); end
    tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL bub_gap got %b want 00", result_valid); end
    tick();
    n_cmp++; if (result_valid !== 2'b01 || result[31:0] !== 3) begin n_err++; $display("FAIL bub_r1 got %b:%0d want 01:3", result_valid, result[31:0]); end
    tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL bub_after got %b want 00", result_valid); end
  endtask

  task automatic test_join();
    lhs[31:0] = 12; rhs[31:0] = 4; lhs_valid = 2'b01; rhs_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (lhs_ready !== 2'b00 || rhs_ready !== 2'b00) begin n_err++; $display("FAIL join_wait%0d got %b/%b want 00/00", c, lhs_ready, rhs_ready); end
      tick();
    end
    rhs_valid = 2'b01; #1;
    n_cmp++; if (lhs_ready !== 2'b01 || rhs_ready !== 2'b01) begin n_err++; $display("FAIL join_fire got %b/%b want 01/01", lhs_ready, rhs_ready); end
    tick(); idle(); tick(); tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL join_early got %b want 00", result_valid); end
    tick();
    n_cmp++; if (result_valid !== 2'b01 || result[31:0] !== 3) begin n_err++; $display("FAIL join_res got %b:%0d want 01:3", result_valid, result[31:0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    lhs = {32'd20, 32'd30}; rhs = {32'd2, 32'd3};
    lhs_valid = 2'b11; rhs_valid = 2'b11;
    tick(); tick(); tick(); idle();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_cmp++; if (result_valid !== 2'b00 || div_ce !== 1'b1) begin n_err++; $display("FAIL rmid_state got %b ce=%b want 00 1", result_valid, div_ce); end
    lhs = {32'd99, 32'd70}; rhs = {32'd9, 32'd7};
    lhs_valid = 2'b11; rhs_valid = 2'b11; #1;
    n_cmp++; if (lhs_ready !== 2'b01) begin n_err++; $display("FAIL rmid_ptr got %b want 01", lhs_ready); end
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL rmid_ghost%0d got %b want 00", c, result_valid); end
      tick();
    end
    n_cmp++; if (result_valid !== 2'b01 || result[31:0] !== 10) begin n_err++; $display("FAIL rmid_res got %b:%0d want 01:10", result_valid, result[31:0]); end
    tick();
    n_cmp++; if (result_valid !== 2'b00) begin n_err++; $display("FAIL rmid_after got %b want 00", result_valid); end
  endtask

  initial begin
    rst = 1'b1; idle(); result_ready = '1; lhs = '0; rhs = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_bubbles();
    test_join();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
